sha256_msg_padder: RTL

Upstream stage of the SHA-256 path in the crypto coprocessor. Accepts a message as a byte stream from the coprocessor datapath and builds one fully padded 512-bit SHA-256 block. The block carries the message bytes, the 0x80 terminator, zero fill and the 64-bit big-endian bit length. It hands the block to the SHA-2 wrapper, whose single-chunk core hashes exactly one block, so messages are limited to 1..55 bytes; longer messages are rejected with an overflow pulse.

---
 rtl/sha256_msg_padder_if.sv | 33 +++
 rtl/sha256_msg_padder.sv | 106 ++++++++++
 2 files changed

// File: rtl/sha256_msg_padder_if.sv
// ----------------------------------------------------------------------------
// sha256_msg_padder_if
// Byte-stream input and padded-block output of the SHA-256 message padder.
//   in_data     [7:0]   message byte, first byte lands in block[511:504]
//   in_valid            in_data / in_last are valid
//   in_last             final byte of the message
//   in_ready            padder accepts a byte this cycle
//   block       [511:0] padded 512-bit block, big-endian byte order
//   block_valid         block is complete and held stable
//   block_ready         consumer takes the block
//   overflow            one-cycle pulse: message too long, discarded
// Modports: master = byte producer / block consumer, slave = padder.
// ----------------------------------------------------------------------------
interface sha256_msg_padder_if;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] block;
   logic         block_valid;
   logic         block_ready;
   logic         overflow;

   modport master (
      output in_data, in_valid, in_last, block_ready,
      input  in_ready, block, block_valid, overflow
   );

   modport slave (
      input  in_data, in_valid, in_last, block_ready,
      output in_ready, block, block_valid, overflow
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// ----------------------------------------------------------------------------
// sha256_msg_padder
// Collects a 1..MAX_BYTES byte message and emits one fully padded SHA-256
// block: message bytes, 0x80 terminator, zero fill, 64-bit bit length.
// Longer messages are swallowed up to their last byte and reported with a
// one-cycle overflow pulse.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    sha256_msg_padder_if.slave (byte stream in, block out, overflow)
// ----------------------------------------------------------------------------
module sha256_msg_padder #(
   parameter int MAX_BYTES = 55
) (
   input logic                  clock,
   input logic                  reset,
   sha256_msg_padder_if.slave   bus
);

   typedef enum logic [1:0] {COLLECT, PAD, OUT, DRAIN} state_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

   state_t       state;
   logic [5:0]   count;
   logic [511:0] msg_buf;
   logic [511:0] pad_blk;
   logic [8:0]   lane_msb;
   logic         beat;

   // Message bit length, zero-extended into the 64-bit length field.
   function automatic logic [63:0] bit_len(input logic [5:0] n);
      return {55'd0, n, 3'b000};
   endfunction

   // Top bit of the byte lane addressed by count (lane 0 = bits 511:504).
   assign lane_msb = 9'd511 - {count, 3'b000};

   // in_ready is a decode of the state, but must read 0 while reset is high.
   assign bus.in_ready = ~reset & ((state == COLLECT) | (state == DRAIN));
   assign beat         = bus.in_valid & bus.in_ready;

   // Buffer with terminator and length applied; lanes beyond are already 0.
   always_comb begin
      pad_blk                 = msg_buf;
      pad_blk[lane_msb -: 8]  = 8'h80;
      pad_blk[63:0]           = bit_len(count);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= COLLECT;
         count           <= '0;
         msg_buf         <= '0;
         bus.block       <= '0;
         bus.block_valid <= 1'b0;
         bus.overflow    <= 1'b0;
      end else begin
         bus.overflow <= 1'b0;
         case (state)
            COLLECT: begin
               if (beat) begin
                  if (count < MAX_CNT) begin
                     msg_buf[lane_msb -: 8] <= bus.in_data;
                     count                  <= count + 6'd1;
                     if (bus.in_last) state <= PAD;
                  end else if (bus.in_last) begin
                     // Exactly one byte too many: reject on the spot.
                     bus.overflow <= 1'b1;
                     msg_buf      <= '0;
                     count        <= '0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            PAD: begin
               msg_buf         <= pad_blk;
               bus.block       <= pad_blk;
               bus.block_valid <= 1'b1;
               state           <= OUT;
            end
            OUT: begin
               if (bus.block_ready) begin
                  msg_buf         <= '0;
                  count           <= '0;
                  bus.block       <= '0;
                  bus.block_valid <= 1'b0;
                  state           <= COLLECT;
               end
            end
            DRAIN: begin
               // Discard the tail of an oversized message until its last byte.
               if (beat && bus.in_last) begin
                  bus.overflow <= 1'b1;
                  msg_buf      <= '0;
                  count        <= '0;
                  state        <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
